reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
- Parametrised successor to the 8x8 CPU register file.
- Configurable data width, register count and number of read ports.
- Adds a synchronous reset, correct per-port write-back forwarding, and a scoreboard (per-register busy bit) with a small issue handshake, so decode can stall on RAW/WAW hazards.
- Sits between decode (read/issue side) and write-back (write side).
- Keeps a combinational debug read port for the display path.

Parameters:
- DATA_W, 8, register width in bits.
- NUM_REGS, 8, number of architectural registers; power of two, at least 2.
- ADDR_W, $clog2(NUM_REGS), register address width (derived; do not override).
- NUM_RD, 2, number of read ports, 1..4.
- ZERO_REG, 1, when 1, register 0 reads as 0, ignores writes and is never busy.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port i uses bits [i*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  read data, combinational, forwarded.
- rd_rdy  out  NUM_RD  1 = rd_data[i] is valid; register not busy, or being written back this cycle.
- iss_en  in  1  decode requests to reserve destination iss_addr.
- iss_addr  in  ADDR_W  destination register of the issuing instruction.
- iss_ok  out  1  combinational grant; the reservation takes effect only when iss_en && iss_ok.
- wr_en  in  1  write-back strobe.
- wr_addr  in  ADDR_W  write-back register.
- wr_data  in  DATA_W  write-back data.
- dbg_addr  in  ADDR_W  display register select.
- dbg_data  out  DATA_W  raw stored value of dbg_addr; no forwarding.
- busy_cnt  out  ADDR_W+1  number of busy registers.

Behaviour:
- Reset, on the clk edge with rst=1: all registers <= 0, all busy bits <= 0, busy_cnt <= 0. rst overrides wr_en and iss_en in the same cycle. Combinational outputs follow the cleared state on the next cycle.
- Write: on the edge with wr_en=1 and not (ZERO_REG && wr_addr==0), regs[wr_addr] <= wr_data and busy[wr_addr] <= 0.
- Write visibility: regs updates one cycle after the write strobe, but forwarding makes the value visible the same cycle.
- Forwarding, evaluated independently per port i:
  - If wr_en && wr_addr==rd_addr[i] && not zero-reg, then rd_data[i]=wr_data and rd_rdy[i]=1.
  - Otherwise rd_data[i]=regs[rd_addr[i]] and rd_rdy[i]=!busy[rd_addr[i]].
  - Two ports reading the same register both forward; the 8x8 file's if/else restriction to one port is explicitly removed.
- Zero register: with ZERO_REG=1, reads of address 0 give 0 with rd_rdy=1, and iss_ok=1 without setting busy.
- Issue grant: iss_ok = !busy[iss_addr] || (wr_en && wr_addr==iss_addr). This refuses WAW while a write is outstanding, but permits reuse in the cycle the pending write retires.
- Issue effect: on the edge with iss_en && iss_ok (and not zero-reg), busy[iss_addr] <= 1. When the same register is written back and issued in the same cycle, the write data is stored and busy ends at 1 (issue wins).
- busy_cnt: registered, equals the popcount of busy at all times. Adjust per cycle by +1 for a set, −1 for a clear, 0 for both or neither. Never underflows: write-back to a non-busy register does not decrement.
- Write-back to a non-busy register is legal (plain write); no error flag.
- Latency: reads and iss_ok are combinational (0 cycles); state updates take 1 cycle.

Decomposition:
- Shared package cpu_pkg: DATA_W and NUM_REGS defaults, reg_addr_t and data_t typedefs, the ZERO_REG constant.
- One sub-module, rf_scoreboard: busy vector, iss_ok, busy_cnt and per-port readiness masks.
- Data storage and forwarding muxes stay in reg_file_sb.

Test Plan:
- Reset: write 0xAA to r3, then rst=1 for one cycle -> all rd_data=0x00, rd_rdy all 1, busy_cnt=0.
- Dual forward: wr_en r5=0x3C with rd_addr={5,5} -> both ports 0x3C, rd_rdy=2'b11 the same cycle; next cycle dbg_addr=5 gives 0x3C.
- Scoreboard stall:
  - iss r2 -> next cycle rd_addr[0]=2 gives rd_rdy[0]=0, busy_cnt=1.
  - wr r2=0x11 -> rd_rdy[0]=1 with 0x11 the same cycle; busy_cnt=0 after the edge.
- WAW: r4 busy, iss_en r4 -> iss_ok=0, busy_cnt unchanged. Same cycle as wr r4=0x22 -> iss_ok=1; r4 holds 0x22, busy[4]=1, busy_cnt=1.
- Zero register: wr r0=0xFF, iss r0 -> rd r0=0x00, rd_rdy=1, iss_ok=1, busy_cnt=0.
- Parameter sweep: DATA_W=16, NUM_REGS=16, NUM_RD=3; iss r15,r14,r13 -> busy_cnt=3; rst mid-pending -> busy_cnt=0, r15 reads 0x0000 ready.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default register-file geometry, address/data types
// and the zero-register helper used by the register file and its scoreboard.
package cpu_pkg;

  localparam int DATA_W_DEF   = 8;
  localparam int NUM_REGS_DEF = 8;
  localparam int ADDR_W_DEF   = $clog2(NUM_REGS_DEF);
  localparam bit ZERO_REG_DEF = 1'b1;

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
  typedef logic [DATA_W_DEF-1:0] data_t;

  // Address is passed zero-extended so one helper serves every file geometry.
  function automatic logic is_zero_reg(input bit zero_en, input logic [31:0] addr);
    logic hit;
    if (zero_en && (addr == 32'd0)) begin
      hit = 1'b1;
    end else begin
      hit = 1'b0;
    end
    return hit;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy tracking: issue grant, busy count and per-read-port
// readiness, including the write-back bypass that makes a busy register ready.
module rf_scoreboard
  import cpu_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = ZERO_REG_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_rdy,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic                     iss_ok,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  output logic [ADDR_W:0]          busy_cnt
);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;
  logic [ADDR_W:0]     cnt_next;
  logic                wr_zero;
  logic                iss_zero;
  logic                wr_fire;
  logic                iss_fire;
  logic                set_new;
  logic                clr_old;

  // Grant and fire decode; a retiring write frees its register for reuse.
  always_comb begin
    wr_zero  = is_zero_reg(ZERO_REG, 32'(wr_addr));
    iss_zero = is_zero_reg(ZERO_REG, 32'(iss_addr));
    wr_fire  = wr_en && !wr_zero;
    if (iss_zero) begin
      iss_ok = 1'b1;
    end else begin
      iss_ok = !busy[iss_addr] || (wr_en && (wr_addr == iss_addr));
    end
    iss_fire = iss_en && iss_ok && !iss_zero;
  end

  // Next busy vector: the clear is applied first so a same-cycle issue wins.
  always_comb begin
    busy_next = busy;
    if (wr_fire) begin
      busy_next[wr_addr] = 1'b0;
    end else begin
      busy_next[wr_addr] = busy[wr_addr];
    end
    if (iss_fire) begin
      busy_next[iss_addr] = 1'b1;
    end else begin
      busy_next[iss_addr] = busy_next[iss_addr];
    end
  end

  // Count delta mirrors real 0->1 / 1->0 transitions, so it cannot underflow.
  always_comb begin
    set_new = iss_fire && !busy[iss_addr];
    clr_old = wr_fire && busy[wr_addr] && !(iss_fire && (iss_addr == wr_addr));
    case ({set_new, clr_old})
      2'b10:   cnt_next = busy_cnt + {{ADDR_W{1'b0}}, 1'b1};
      2'b01:   cnt_next = busy_cnt - {{ADDR_W{1'b0}}, 1'b1};
      default: cnt_next = busy_cnt;
    endcase
  end

  // Per-port readiness: bypassed write-back or register not reserved.
  always_comb begin
    rd_rdy = {NUM_RD{1'b0}};
    for (int p = 0; p < NUM_RD; p++) begin
      if (wr_fire && (wr_addr == rd_addr[p*ADDR_W +: ADDR_W])) begin
        rd_rdy[p] = 1'b1;
      end else begin
        rd_rdy[p] = !busy[rd_addr[p*ADDR_W +: ADDR_W]];
      end
    end
  end

  // Busy vector and count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= {NUM_REGS{1'b0}};
      busy_cnt <= {(ADDR_W+1){1'b0}};
    end else begin
      busy     <= busy_next;
      busy_cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Parametrised register file with per-port write-back forwarding, an optional
// hard-wired zero register, a raw debug read port and a hazard scoreboard.
module reg_file_sb
  import cpu_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = ZERO_REG_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_rdy,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic                     iss_ok,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [ADDR_W-1:0]        dbg_addr,
  output logic [DATA_W-1:0]        dbg_data,
  output logic [ADDR_W:0]          busy_cnt
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wr_fire;

  // Writes to the zero register are dropped everywhere, including forwarding.
  always_comb begin
    wr_fire = wr_en && !is_zero_reg(ZERO_REG, 32'(wr_addr));
  end

  // Storage array.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs[r] <= {DATA_W{1'b0}};
      end
    end else if (wr_fire) begin
      regs[wr_addr] <= wr_data;
    end else begin
      regs[wr_addr] <= regs[wr_addr];
    end
  end

  // Read muxes: every port independently sees this cycle's write-back data.
  always_comb begin
    rd_data = {(NUM_RD*DATA_W){1'b0}};
    for (int p = 0; p < NUM_RD; p++) begin
      if (is_zero_reg(ZERO_REG, 32'(rd_addr[p*ADDR_W +: ADDR_W]))) begin
        rd_data[p*DATA_W +: DATA_W] = {DATA_W{1'b0}};
      end else if (wr_fire && (wr_addr == rd_addr[p*ADDR_W +: ADDR_W])) begin
        rd_data[p*DATA_W +: DATA_W] = wr_data;
      end else begin
        rd_data[p*DATA_W +: DATA_W] = regs[rd_addr[p*ADDR_W +: ADDR_W]];
      end
    end
  end

  // Display path shows the stored value only, never the bypass.
  always_comb begin
    dbg_data = regs[dbg_addr];
  end

  rf_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (rd_addr),
    .rd_rdy   (rd_rdy),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .iss_ok   (iss_ok),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .busy_cnt (busy_cnt)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed, table-driven bench for reg_file_sb: default 8x8 two-port file plus
// a 16x16 three-port instance for the parameter sweep.
`timescale 1ns/1ps
module tb_reg_file_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Default geometry instance
  logic        rst8;
  logic [5:0]  rd_addr8;
  logic [15:0] rd_data8;
  logic [1:0]  rd_rdy8;
  logic        iss_en8, iss_ok8, wr_en8;
  logic [2:0]  iss_addr8, wr_addr8, dbg_addr8;
  logic [7:0]  wr_data8, dbg_data8;
  logic [3:0]  busy_cnt8;

  reg_file_sb u8 (
    .clk(clk), .rst(rst8), .rd_addr(rd_addr8), .rd_data(rd_data8), .rd_rdy(rd_rdy8),
    .iss_en(iss_en8), .iss_addr(iss_addr8), .iss_ok(iss_ok8),
    .wr_en(wr_en8), .wr_addr(wr_addr8), .wr_data(wr_data8),
    .dbg_addr(dbg_addr8), .dbg_data(dbg_data8), .busy_cnt(busy_cnt8)
  );

  // Swept geometry instance
  logic        rst16;
  logic [11:0] rd_addr16;
  logic [47:0] rd_data16;
  logic [2:0]  rd_rdy16;
  logic        iss_en16, iss_ok16, wr_en16;
  logic [3:0]  iss_addr16, wr_addr16, dbg_addr16;
  logic [15:0] wr_data16, dbg_data16;
  logic [4:0]  busy_cnt16;

  reg_file_sb #(.DATA_W(16), .NUM_REGS(16), .NUM_RD(3)) u16 (
    .clk(clk), .rst(rst16), .rd_addr(rd_addr16), .rd_data(rd_data16), .rd_rdy(rd_rdy16),
    .iss_en(iss_en16), .iss_addr(iss_addr16), .iss_ok(iss_ok16),
    .wr_en(wr_en16), .wr_addr(wr_addr16), .wr_data(wr_data16),
    .dbg_addr(dbg_addr16), .dbg_data(dbg_data16), .busy_cnt(busy_cnt16)
  );

  typedef struct {
    logic       rst;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       iss_en;
    logic [2:0] iss_addr;
    logic [2:0] rd0, rd1, dbg;
    logic [7:0] e_rd0, e_rd1;
    logic [1:0] e_rdy;
    logic       e_ok;
    logic [7:0] e_dbg;
    logic [3:0] e_cnt;
  } vec_t;

  vec_t tbl [19];

  function automatic vec_t mk(logic r, logic we, logic [2:0] wa, logic [7:0] wd,
                              logic ie, logic [2:0] ia, logic [2:0] a0, logic [2:0] a1,
                              logic [2:0] da, logic [7:0] d0, logic [7:0] d1,
                              logic [1:0] rdy, logic ok, logic [7:0] dd, logic [3:0] cnt);
    vec_t v;
    v.rst = r; v.wr_en = we; v.wr_addr = wa; v.wr_data = wd;
    v.iss_en = ie; v.iss_addr = ia; v.rd0 = a0; v.rd1 = a1; v.dbg = da;
    v.e_rd0 = d0; v.e_rd1 = d1; v.e_rdy = rdy; v.e_ok = ok; v.e_dbg = dd; v.e_cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle8();
    rst8 = 1'b0; wr_en8 = 1'b0; wr_addr8 = 3'd0; wr_data8 = 8'h00;
    iss_en8 = 1'b0; iss_addr8 = 3'd0; rd_addr8 = 6'd0; dbg_addr8 = 3'd0;
  endtask

  task automatic idle16();
    rst16 = 1'b0; wr_en16 = 1'b0; wr_addr16 = 4'd0; wr_data16 = 16'h0000;
    iss_en16 = 1'b0; iss_addr16 = 4'd0; rd_addr16 = 12'd0; dbg_addr16 = 4'd0;
  endtask

  initial begin
    //            rst we wa  wd     ie ia a0 a1 dbg  rd0    rd1    rdy    ok dbg    cnt
    tbl[0]  = mk(0, 1, 3, 8'hAA, 0, 0, 3, 3, 3, 8'hAA, 8'hAA, 2'b11, 1, 8'h00, 4'd0);
    tbl[1]  = mk(1, 1, 1, 8'h55, 1, 6, 3, 3, 3, 8'hAA, 8'hAA, 2'b11, 1, 8'hAA, 4'd0);
    tbl[2]  = mk(0, 0, 0, 8'h00, 0, 6, 3, 6, 1, 8'h00, 8'h00, 2'b11, 1, 8'h00, 4'd0);
    tbl[3]  = mk(0, 1, 5, 8'h3C, 0, 0, 5, 5, 5, 8'h3C, 8'h3C, 2'b11, 1, 8'h00, 4'd0);
    tbl[4]  = mk(0, 0, 0, 8'h00, 0, 0, 5, 0, 5, 8'h3C, 8'h00, 2'b11, 1, 8'h3C, 4'd0);
    tbl[5]  = mk(0, 0, 0, 8'h00, 1, 2, 2, 5, 2, 8'h00, 8'h3C, 2'b11, 1, 8'h00, 4'd0);
    tbl[6]  = mk(0, 0, 0, 8'h00, 0, 2, 2, 5, 2, 8'h00, 8'h3C, 2'b10, 0, 8'h00, 4'd1);
    tbl[7]  = mk(0, 1, 2, 8'h11, 0, 2, 2, 2, 2, 8'h11, 8'h11, 2'b11, 1, 8'h00, 4'd1);
    tbl[8]  = mk(0, 0, 0, 8'h00, 1, 4, 2, 4, 2, 8'h11, 8'h00, 2'b11, 1, 8'h11, 4'd0);
    tbl[9]  = mk(0, 0, 0, 8'h00, 1, 4, 4, 2, 4, 8'h00, 8'h11, 2'b10, 0, 8'h00, 4'd1);
    tbl[10] = mk(0, 1, 4, 8'h22, 1, 4, 4, 4, 4, 8'h22, 8'h22, 2'b11, 1, 8'h00, 4'd1);
    tbl[11] = mk(0, 0, 0, 8'h00, 0, 4, 4, 0, 4, 8'h22, 8'h00, 2'b10, 0, 8'h22, 4'd1);
    tbl[12] = mk(0, 1, 0, 8'hFF, 1, 0, 0, 0, 0, 8'h00, 8'h00, 2'b11, 1, 8'h00, 4'd1);
    tbl[13] = mk(0, 0, 0, 8'h00, 0, 0, 0, 4, 0, 8'h00, 8'h22, 2'b01, 1, 8'h00, 4'd1);
    tbl[14] = mk(0, 1, 7, 8'h09, 0, 0, 7, 4, 7, 8'h09, 8'h22, 2'b01, 1, 8'h00, 4'd1);
    tbl[15] = mk(0, 1, 4, 8'h33, 1, 7, 4, 7, 4, 8'h33, 8'h09, 2'b11, 1, 8'h22, 4'd1);
    tbl[16] = mk(0, 0, 0, 8'h00, 0, 7, 4, 7, 4, 8'h33, 8'h09, 2'b01, 0, 8'h33, 4'd1);
    tbl[17] = mk(0, 1, 7, 8'h44, 0, 0, 7, 1, 7, 8'h44, 8'h00, 2'b11, 1, 8'h09, 4'd1);
    tbl[18] = mk(0, 0, 0, 8'h00, 0, 0, 7, 0, 7, 8'h44, 8'h00, 2'b11, 1, 8'h44, 4'd0);

    idle8();
    idle16();
    rst8 = 1'b1;
    rst16 = 1'b1;
    @(negedge clk);
    idle8();
    idle16();
    rd_addr8 = {3'd3, 3'd3};
    #2;
    chk("reset_rd", {48'd0, rd_data8}, 64'h0);
    chk("reset_rdy", {62'd0, rd_rdy8}, 64'h3);
    chk("reset_cnt", {60'd0, busy_cnt8}, 64'h0);

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      rst8 = tbl[i].rst; wr_en8 = tbl[i].wr_en; wr_addr8 = tbl[i].wr_addr;
      wr_data8 = tbl[i].wr_data; iss_en8 = tbl[i].iss_en; iss_addr8 = tbl[i].iss_addr;
      rd_addr8 = {tbl[i].rd1, tbl[i].rd0}; dbg_addr8 = tbl[i].dbg;
      #2;
      chk($sformatf("v%0d_rd0", i), {56'd0, rd_data8[7:0]}, {56'd0, tbl[i].e_rd0});
      chk($sformatf("v%0d_rd1", i), {56'd0, rd_data8[15:8]}, {56'd0, tbl[i].e_rd1});
      chk($sformatf("v%0d_rdy", i), {62'd0, rd_rdy8}, {62'd0, tbl[i].e_rdy});
      chk($sformatf("v%0d_iss_ok", i), {63'd0, iss_ok8}, {63'd0, tbl[i].e_ok});
      chk($sformatf("v%0d_dbg", i), {56'd0, dbg_data8}, {56'd0, tbl[i].e_dbg});
      chk($sformatf("v%0d_cnt", i), {60'd0, busy_cnt8}, {60'd0, tbl[i].e_cnt});
    end
    @(negedge clk);
    idle8();

    // Three-port forward of one register
    wr_en16 = 1'b1; wr_addr16 = 4'd9; wr_data16 = 16'h1234;
    rd_addr16 = {4'd9, 4'd9, 4'd9};
    #2;
    chk("p_fwd3_data", {16'd0, rd_data16}, {16'd0, 16'h1234, 16'h1234, 16'h1234});
    chk("p_fwd3_rdy", {61'd0, rd_rdy16}, 64'h7);
    chk("p_fwd3_cnt", {59'd0, busy_cnt16}, 64'h0);

    // Write r15 and reserve it in the same cycle: data stored, busy kept
    @(negedge clk);
    idle16();
    wr_en16 = 1'b1; wr_addr16 = 4'd15; wr_data16 = 16'hBEEF;
    iss_en16 = 1'b1; iss_addr16 = 4'd15;
    #2;
    chk("p_iss15_ok", {63'd0, iss_ok16}, 64'h1);
    @(negedge clk);
    idle16();
    iss_en16 = 1'b1; iss_addr16 = 4'd14;
    #2;
    chk("p_iss14_ok", {63'd0, iss_ok16}, 64'h1);
    chk("p_cnt_1", {59'd0, busy_cnt16}, 64'h1);
    @(negedge clk);
    idle16();
    iss_en16 = 1'b1; iss_addr16 = 4'd13;
    #2;
    chk("p_iss13_ok", {63'd0, iss_ok16}, 64'h1);
    @(negedge clk);
    idle16();
    rd_addr16 = {4'd13, 4'd14, 4'd15};
    dbg_addr16 = 4'd15;
    iss_addr16 = 4'd14;
    #2;
    chk("p_cnt_3", {59'd0, busy_cnt16}, 64'h3);
    chk("p_busy_rdy", {61'd0, rd_rdy16}, 64'h0);
    chk("p_r15_raw", {48'd0, rd_data16[15:0]}, 64'hBEEF);
    chk("p_dbg15", {48'd0, dbg_data16}, 64'hBEEF);
    chk("p_waw_ok", {63'd0, iss_ok16}, 64'h0);

    // Reset with reservations pending, issue in the same cycle is overridden
    @(negedge clk);
    idle16();
    rst16 = 1'b1; iss_en16 = 1'b1; iss_addr16 = 4'd12;
    @(negedge clk);
    idle16();
    rd_addr16 = {4'd12, 4'd9, 4'd15};
    dbg_addr16 = 4'd9;
    iss_addr16 = 4'd15;
    #2;
    chk("p_rst_cnt", {59'd0, busy_cnt16}, 64'h0);
    chk("p_rst_data", {16'd0, rd_data16}, 64'h0);
    chk("p_rst_rdy", {61'd0, rd_rdy16}, 64'h7);
    chk("p_rst_dbg", {48'd0, dbg_data16}, 64'h0);
    chk("p_rst_iss_ok", {63'd0, iss_ok16}, 64'h1);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
